// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//
// Debouncer and edge detector for a level that has already passed through the
// two-flop synchronizer. A change of the input is only accepted after it has
// been sampled at the new value on STABLE_CYCLES consecutive rising edges.
// Once accepted, the block updates a clean level, emits a single-cycle
// rise/fall pulse and (optionally) counts accepted rising edges.
//
// Parameters
//   STABLE_CYCLES : consecutive identical samples needed to accept a change
//                   (must be >= 2)
//   COUNT_W       : width of the presses counter
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   reset   : asynchronous, active-high reset
//   d       : synchronized raw level (no further synchronization here)
//   level   : debounced level
//   rise    : one-cycle pulse when level goes 0 -> 1
//   fall    : one-cycle pulse when level goes 1 -> 0
//   busy    : high while a candidate change is being qualified
//   presses : count of accepted rising edges, wraps modulo 2**COUNT_W
//
// Build option
//   DEBOUNCE_COUNT_EN : when defined, the presses counter is built; when
//                       undefined, no counter flops exist and presses is 0.
// -----------------------------------------------------------------------------
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d,
  output logic               level,
  output logic               rise,
  output logic               fall,
  output logic               busy,
  output logic [COUNT_W-1:0] presses
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept_rise;
  logic             accept_fall;

  // Next-state logic. cnt counts samples already seen at the candidate value,
  // so entering a WAIT state loads 1 and the change is accepted when the
  // STABLE_CYCLES-th matching sample arrives (cnt == STABLE_CYCLES-1).
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path through the case leaves a signal unassigned and infers a latch.
    state_next  = state;
    cnt_next    = '0;
    accept_rise = 1'b0;
    accept_fall = 1'b0;

    case (state)
      LOW: begin
        if (d) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end

      WAIT_HIGH: begin
        if (!d) begin
          state_next = LOW;
        end else if (cnt == CNT_LAST) begin
          state_next  = HIGH;
          accept_rise = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      HIGH: begin
        if (!d) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end

      WAIT_LOW: begin
        if (d) begin
          state_next = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_next  = LOW;
          accept_fall = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        state_next = LOW;
      end
    endcase
  end

  // State, counter and registered outputs. level and busy are decodes of the
  // next state captured in flops, so they are glitch-free and line up exactly
  // with the state they describe. rise/fall load the one-cycle accept strobes
  // and therefore clear on the following edge by construction.
  // NOTE: reset is asynchronous; the sensitivity list includes posedge reset
  // so outputs clear immediately, including a pulse that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state <= state_next;
      cnt   <= cnt_next;
      level <= (state_next == HIGH) || (state_next == WAIT_LOW);
      busy  <= (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
      rise  <= accept_rise;
      fall  <= accept_fall;
    end
  end

`ifdef DEBOUNCE_COUNT_EN
  // Wrapping count of accepted rising edges; all-ones rolls over to zero.
  logic [COUNT_W-1:0] press_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt <= '0;
    end else if (accept_rise) begin
      press_cnt <= press_cnt + COUNT_W'(1);
    end
  end

  assign presses = press_cnt;
`else
  assign presses = '0;
`endif

endmodule
